// File: rtl/sound_pkg.sv
// Shared constants and types for the sound sample player.
package sound_pkg;

    localparam int ADDR_W     = 18;
    localparam int DATA_W     = 4;
    localparam int PWM_PERIOD = 15;

    // Midscale level that produces a quiet output when idle.
    localparam logic [DATA_W-1:0] SILENCE = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        HOLD
    } state_t;

endpackage

// File: rtl/sound_player_if.sv
// Read port between the sound player and the sample ROM (1-cycle registered read).
interface sound_player_if #(
    parameter int ADDR_W = sound_pkg::ADDR_W,
    parameter int DATA_W = sound_pkg::DATA_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, input mem_rdata);
    modport slave  (input mem_addr, output mem_rdata);
endinterface

// File: rtl/sound_player_pwm_dac.sv
// 1-bit PWM DAC: free-running counter over PWM_PERIOD clocks, output high
// while the counter is below the level, so duty = level / PWM_PERIOD.
module pwm_dac
    import sound_pkg::*;
#(
    parameter int DATA_W = sound_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] level,
    output logic              pwm_out
);

    localparam logic [DATA_W-1:0] CNT_LAST = DATA_W'(PWM_PERIOD - 1);

    logic [DATA_W-1:0] pwm_cnt;

    // Counter wraps at PWM_PERIOD-1 so a full-scale level gives a constant high.
    // NOTE: reset is sampled at the clock edge (synchronous), so it lives inside the
    // clocked block, and every register here is updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
            pwm_out <= (pwm_cnt < level);
        end
    end

endmodule

// File: rtl/sound_player.sv
// Sound sample player: walks ROM addresses START_ADDR..END_ADDR, holding each
// 4-bit sample for SAMPLE_DIV clocks, and drives it in parallel and via PWM.
module sound_player
    import sound_pkg::*;
#(
    parameter int                ADDR_W     = sound_pkg::ADDR_W,
    parameter int                DATA_W     = sound_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = '1,
    parameter int                SAMPLE_DIV = 3125,
    parameter logic [DATA_W-1:0] SILENCE    = sound_pkg::SILENCE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              stop,
    input  logic              loop_en,
    sound_player_if.master    mem,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              pwm_out
);

    // HOLD lasts SAMPLE_DIV-2 cycles; together with FETCH and LOAD that makes
    // exactly SAMPLE_DIV cycles between sample_valid pulses.
    localparam int                DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 3);

    if (START_ADDR > END_ADDR) begin : g_bad_range
        $fatal(1, "sound_player: START_ADDR must not exceed END_ADDR");
    end

    if (SAMPLE_DIV < 3) begin : g_bad_div
        $fatal(1, "sound_player: SAMPLE_DIV must be at least 3");
    end

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DIV_W-1:0]  div_cnt;

    assign mem.mem_addr = ptr;

    // Playback sequencer: stop beats everything, otherwise fetch/load/hold per sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= START_ADDR;
            div_cnt      <= '0;
            sample       <= SILENCE;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                ptr     <= START_ADDR;
                div_cnt <= '0;
                sample  <= SILENCE;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (play) begin
                            ptr   <= START_ADDR;
                            state <= FETCH;
                            busy  <= 1'b1;
                        end
                    end
                    FETCH: begin
                        state <= LOAD;
                    end
                    LOAD: begin
                        sample       <= mem.mem_rdata;
                        sample_valid <= 1'b1;
                        div_cnt      <= '0;
                        state        <= HOLD;
                    end
                    HOLD: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            if (ptr != END_ADDR) begin
                                ptr   <= ptr + 1'b1;
                                state <= FETCH;
                            end else if (loop_en) begin
                                ptr   <= START_ADDR;
                                state <= FETCH;
                            end else begin
                                ptr    <= START_ADDR;
                                sample <= SILENCE;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                state  <= IDLE;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    pwm_dac #(
        .DATA_W (DATA_W)
    ) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .level   (sample),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_sound_player.sv
// Directed bench for sound_player: 4-sample ROM (1,2,3,4), SAMPLE_DIV=4,
// plus a single-sample instance for PWM extremes.
module tb_sound_player;
    import sound_pkg::*;

    localparam int AW  = 18;
    localparam int DW  = 4;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Main instance: addresses 0..3
    logic          play = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [DW-1:0] sample;
    logic          sample_valid, busy, done, pwm_out;
    logic [DW-1:0] rom [0:3] = '{4'd1, 4'd2, 4'd3, 4'd4};

    sound_player_if #(.ADDR_W(AW), .DATA_W(DW)) mem_a ();

    always @(posedge clk) mem_a.mem_rdata <= rom[mem_a.mem_addr[1:0]];

    sound_player #(
        .ADDR_W(AW), .DATA_W(DW), .START_ADDR(18'd0), .END_ADDR(18'd3),
        .SAMPLE_DIV(DIV), .SILENCE(4'd8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .play(play), .stop(stop), .loop_en(loop_en),
        .mem(mem_a), .sample(sample), .sample_valid(sample_valid),
        .busy(busy), .done(done), .pwm_out(pwm_out)
    );

    // Second instance: single sample at address 0, value set by the bench
    logic          play2 = 1'b0, stop2 = 1'b0, loop2 = 1'b0;
    logic [DW-1:0] sample2;
    logic          sample_valid2, busy2, done2, pwm_out2;
    logic [DW-1:0] rom2 = 4'd0;

    sound_player_if #(.ADDR_W(AW), .DATA_W(DW)) mem_b ();

    always @(posedge clk) mem_b.mem_rdata <= rom2;

    sound_player #(
        .ADDR_W(AW), .DATA_W(DW), .START_ADDR(18'd0), .END_ADDR(18'd0),
        .SAMPLE_DIV(DIV), .SILENCE(4'd8)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .play(play2), .stop(stop2), .loop_en(loop2),
        .mem(mem_b), .sample(sample2), .sample_valid(sample_valid2),
        .busy(busy2), .done(done2), .pwm_out(pwm_out2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle outputs after a play pulse in cycle 0 (hand-derived:
    // pulses at 3,7,11,15 carrying 1,2,3,4; done at 17; looping repeats from 17).
    function automatic logic exp_sv(int n, bit lp);
        return (n % 4 == 3) && (lp || n <= 15);
    endfunction

    function automatic logic [3:0] exp_sample(int n, bit lp);
        logic [3:0] seq [0:3];
        seq = '{4'd1, 4'd2, 4'd3, 4'd4};
        if (n < 3) return 4'd8;
        if (!lp && n >= 17) return 4'd8;
        return seq[((n - 3) / 4) % 4];
    endfunction

    task automatic play_run(input bit lp, input bit replay);
        play    = 1'b1;
        loop_en = lp;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 1) play = 1'b0;
            if (replay && n == 5) play = 1'b1;
            if (replay && n == 6) play = 1'b0;
            check($sformatf("sv c%0d lp%0d", n, lp), sample_valid, exp_sv(n, lp));
            check($sformatf("sample c%0d lp%0d", n, lp), sample, exp_sample(n, lp));
            check($sformatf("busy c%0d lp%0d", n, lp), busy, lp ? 1'b1 : (n <= 16));
            check($sformatf("done c%0d lp%0d", n, lp), done, !lp && n == 17);
            if (n % 4 == 1 && (lp || n <= 13))
                check($sformatf("addr c%0d lp%0d", n, lp), mem_a.mem_addr, ((n - 1) / 4) % 4);
        end
    endtask

    task automatic count_high(input bit second, output int highs);
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (second ? pwm_out2 : pwm_out) highs++;
        end
    endtask

    initial begin
        int highs;
        bit seen;

        // Power-on reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("por busy", busy, 1'b0);
        check("por sample", sample, 4'd8);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain playback, no loop
        play_run(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // play re-asserted while busy must not disturb the sequence
        play_run(1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Looping playback, then stop
        play_run(1'b1, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop_en = 1'b0;
        check("loop stop busy", busy, 1'b0);
        check("loop stop sample", sample, 4'd8);
        repeat (2) @(negedge clk);

        // Stop in the middle of playback (cycle 9)
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        repeat (8) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop busy", busy, 1'b0);
        check("stop sample", sample, 4'd8);
        check("stop done", done, 1'b0);
        check("stop sv", sample_valid, 1'b0);
        check("stop addr", mem_a.mem_addr, 18'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || sample_valid || busy) seen = 1'b1;
        end
        check("stop quiet after", seen, 1'b0);

        // play and stop together in IDLE: stop wins
        play = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        play = 1'b0;
        stop = 1'b0;
        check("play+stop busy", busy, 1'b0);
        @(negedge clk);
        check("play+stop busy2", busy, 1'b0);

        // Reset in the middle of playback
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", busy, 1'b0);
        check("rst addr", mem_a.mem_addr, 18'd0);
        check("rst sample", sample, 4'd8);
        check("rst sv", sample_valid, 1'b0);
        check("rst done", done, 1'b0);
        check("rst pwm", pwm_out, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst busy", busy, 1'b0);
        check("post-rst sample", sample, 4'd8);
        check("post-rst sv", sample_valid, 1'b0);

        // PWM at idle midscale: 8 of every 15 cycles high
        repeat (3) @(negedge clk);
        count_high(1'b0, highs);
        check("pwm idle highs", highs, 8);

        // PWM extremes with a single looping sample
        rom2  = 4'd0;
        loop2 = 1'b1;
        play2 = 1'b1;
        @(negedge clk);
        play2 = 1'b0;
        repeat (20) @(negedge clk);
        check("single busy", busy2, 1'b1);
        check("single sample 0", sample2, 4'd0);
        count_high(1'b1, highs);
        check("pwm zero highs", highs, 0);
        rom2 = 4'd15;
        repeat (25) @(negedge clk);
        check("single sample 15", sample2, 4'd15);
        count_high(1'b1, highs);
        check("pwm full highs", highs, 15);
        check("single no done", done2, 1'b0);
        stop2 = 1'b1;
        @(negedge clk);
        stop2 = 1'b0;
        check("single stop busy", busy2, 1'b0);
        check("single stop sample", sample2, 4'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
